// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: valid/ready front end that holds ALU operands for ALU_LATENCY cycles, then returns y1/y2.
// Optional macro ALU_SEQ_OPCHECK_EN rejects ops 3'b100..3'b111 with resp_err instead of issuing them.
module alu_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int RWIDTH = 32,
    parameter int ALU_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic              req_cplx,
    input  logic [WIDTH-1:0]  req_a,
    input  logic [WIDTH-1:0]  req_b,
    input  logic [WIDTH-1:0]  req_ai,
    input  logic [WIDTH-1:0]  req_bi,
    output logic [2:0]        alu_chooser,
    output logic              alu_is_complex,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [WIDTH-1:0]  alu_ai,
    output logic [WIDTH-1:0]  alu_bi,
    input  logic [RWIDTH-1:0] alu_y1,
    input  logic [RWIDTH-1:0] alu_y2,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RWIDTH-1:0] resp_y1,
    output logic [RWIDTH-1:0] resp_y2,
    output logic [2:0]        resp_op,
    output logic              resp_err
);
    localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2;
    logic [1:0] state;
    logic [3:0] cnt;
    logic       illegal;
    assign req_ready  = state == IDLE;
    assign resp_valid = state == RESP;
`ifdef ALU_SEQ_OPCHECK_EN
    assign illegal = req_op[2];
`else
    assign illegal = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            alu_chooser    <= '0;
            alu_is_complex <= 1'b0;
            alu_a          <= '0;
            alu_b          <= '0;
            alu_ai         <= '0;
            alu_bi         <= '0;
            resp_y1        <= '0;
            resp_y2        <= '0;
            resp_op        <= '0;
        end else if (state == IDLE && req_valid) begin
            if (illegal) begin
                // rejected ops never reach the ALU and answer on the next cycle
                state   <= RESP;
                resp_y1 <= '0;
                resp_y2 <= '0;
                resp_op <= req_op;
            end else begin
                state          <= SETTLE;
                cnt            <= 4'(ALU_LATENCY - 1);
                alu_chooser    <= req_op;
                alu_is_complex <= req_cplx;
                alu_a          <= req_a;
                alu_b          <= req_b;
                alu_ai         <= req_ai;
                alu_bi         <= req_bi;
            end
        end else if (state == SETTLE) begin
            if (cnt == '0) begin
                state   <= RESP;
                resp_y1 <= alu_y1;
                resp_y2 <= alu_y2;
                resp_op <= alu_chooser;
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (state == RESP && resp_ready) begin
            state <= IDLE;
        end
    end
`ifdef ALU_SEQ_OPCHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            resp_err <= 1'b0;
        else if (state == IDLE && req_valid)
            resp_err <= illegal;
    end
`else
    assign resp_err = 1'b0;
`endif
endmodule
